// File: rtl/shared_adder_sched.sv
// Bit-serial WIDTH-bit adder time-shared between two requesters.
// Round-robin grant in IDLE, one sum bit per cycle in ADD, result held in DONE.
module shared_adder_sched #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_sum,
    output logic             res_id,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_last_grant;
    logic [WIDTH:0]   r_sum;
    logic             r_res_valid;

    logic w_idle;
    logic w_grant0;
    logic w_grant1;
    logic w_bit_a;
    logic w_bit_b;
    logic w_sum_bit;
    logic w_cout;

    // A contested cycle goes to whichever requester did not win last time.
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_grant0 = w_idle && req0_valid && (!req1_valid || r_last_grant);
        w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    end

    always_comb begin
        w_bit_a   = r_a[r_idx];
        w_bit_b   = r_b[r_idx];
        w_sum_bit = w_bit_a ^ w_bit_b ^ r_carry;
        w_cout    = (w_bit_a & w_bit_b) | (w_bit_a & r_carry) | (w_bit_b & r_carry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_carry      <= 1'b0;
            r_idx        <= '0;
            r_last_grant <= 1'b1;
            r_sum        <= '0;
            r_res_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_a          <= w_grant1 ? req1_a : req0_a;
                        r_b          <= w_grant1 ? req1_b : req0_b;
                        r_id         <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_carry      <= 1'b0;
                        r_idx        <= '0;
                        r_state      <= S_ADD;
                    end
                end
                S_ADD: begin
                    r_sum[r_idx] <= w_sum_bit;
                    r_carry      <= w_cout;
                    r_idx        <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_sum[WIDTH] <= w_cout;
                        r_res_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign res_valid  = r_res_valid;
    assign res_sum    = r_sum;
    assign res_id     = r_id;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/shared_adder_sched.md
Name: shared_adder_sched

Overview:
- Time-multiplexes one 1-bit full-adder slice between two requesters.
- Each accepted operation is a WIDTH-bit add, performed bit-serially, LSB first, one bit per cycle.
- Requesters are arbitrated round-robin over valid/ready handshakes.
- The result is returned on a single valid/ready output channel, tagged with the requester ID.
- Replaces a parallel ripple adder where area matters more than throughput.

Parameters:
WIDTH, 3, operand width in bits; result is WIDTH+1 bits.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  requester 0 operand A
req0_b  in  WIDTH  requester 0 operand B
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_a  in  WIDTH  requester 1 operand A
req1_b  in  WIDTH  requester 1 operand B
res_valid  out  1  result available
res_ready  in  1  consumer takes result
res_sum  out  WIDTH+1  unsigned sum; MSB is carry-out
res_id  out  1  requester that issued the operation
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, res_valid=0, res_sum=0, res_id=0, busy=0, carry=0, bit index=0, last_grant=1.
  - last_grant=1 makes req0 win the first contested cycle.
- req0_ready and req1_ready are combinational and only high in IDLE.
  - At most one is high in a cycle.
  - ready may depend on valid; valid must never depend on ready.
- Grant in IDLE:
  - Only one valid: that requester.
  - Both valid: the requester != last_grant.
- Handshake: valid & ready at a rising edge.
  - Capture a, b and id.
  - Set carry=0, index=0, last_grant=id.
  - Next state ADD.
- Operands are sampled only at the handshake; later input changes are ignored.
- ADD: each cycle, with i=index:
  - res_sum[i] <= a[i]^b[i]^carry
  - carry <= majority(a[i],b[i],carry)
  - index <= index+1
  - When i==WIDTH-1, also res_sum[WIDTH] <= carry-out of that bit, and next state is DONE.
  - ADD lasts exactly WIDTH cycles.
- DONE:
  - res_valid=1; res_sum and res_id held stable.
  - On res_valid & res_ready: res_valid<=0, next state IDLE.
  - No new request is accepted in the same cycle as the DONE handshake.
- Latency: handshake at edge E0 → res_valid high after edge E0+WIDTH.
- Best-case throughput: one operation per WIDTH+2 cycles.
- Arithmetic: unsigned, modulo nothing. The full WIDTH+1-bit sum is always exact, e.g. 7+7=14.
- res_sum register contents are undefined while busy and res_valid=0; the bench must only check them when res_valid=1.
- Backpressure: res_ready low holds DONE indefinitely. Both ready outputs stay 0; pending requests wait, no drop.
- Reset mid-operation (ADD or DONE):
  - Immediately IDLE, res_valid=0; the in-flight result is discarded.
  - last_grant returns to 1.
- A requester that drops valid before ready is not an error; it simply is not granted.
- Arbitration is re-evaluated every IDLE cycle.
- busy=1 in ADD and DONE.

Test Plan:
- Reset: hold rst_n=0 mid-clock with random inputs → all outputs 0, both ready 0 with no valid.
- Single op, WIDTH=3: req0 valid, a=5, b=3, res_ready=1 → req0_ready in the same cycle; res_valid 3 edges after handshake with res_sum=4'b1000, res_id=0; then IDLE.
- Exhaustive: all 64 (a,b) pairs via req1 → res_sum==a+b each time, including 7+7=14 and 0+0=0, res_id=1.
- Contention: both valid continuously with distinct operands, res_ready=1 → grants 0,1,0,1; each result matches its operands and id.
- Backpressure: res_ready=0 for 6 cycles in DONE with req1 valid → res_valid/res_sum/res_id stable, req1_ready=0; res_ready=1 → result taken, req1 granted next IDLE cycle.
- Reset mid-ADD: assert rst_n=0 at bit 1 of a req0 op → no res_valid appears; after release, a new req1 op 2+2 completes with 4.
